frame_generator_multi: RTL

- Next-generation test-frame source for one tester port; replaces the single-mode generator.
- Emits IPv4-over-Ethernet test frames on an AXI-Stream master. Data width is parametrised, and each frame carries a payload sequence number.
- Supports three size modes (fixed / sweep / random), a programmable inter-frame gap and an optional frame-count limit.
- Exports sent-frame and sent-byte counters; sits between the per-port config registers and the MAC TX FIFO.

---
 rtl/tester_common_pkg.sv | 55 +++++
 rtl/frame_generator_multi_size.sv | 64 ++++++
 rtl/frame_generator_multi.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/tester_common_pkg.sv
// Shared tester types: generator config, size modes, frame constants
// and the small LFSR / IPv4 checksum helpers used by the generators.
package tester_common;

    localparam int MIN_FRAME_BYTES = 64;
    localparam int MAX_FRAME_BYTES = 9018;
    localparam int SEQ_OFFSET      = 34;

    localparam logic [7:0] TEST_FRAME_TOS   = 8'h00;
    localparam logic [7:0] TEST_FRAME_PROTO = 8'hFD;
    localparam logic [7:0] TEST_FRAME_TTL   = 8'd64;

    typedef enum logic [1:0] {
        SIZE_FIXED,
        SIZE_SWEEP,
        SIZE_RANDOM
    } size_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SENDING,
        ST_GAP
    } gen_state_t;

    typedef struct packed {
        logic        enable;
        logic [47:0] src_mac;
        logic [47:0] dst_mac;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        size_mode_t  size_mode;
        logic [13:0] size_min;
        logic [13:0] size_max;
        logic [13:0] size_step;
        logic [15:0] gap_cycles;
        logic [31:0] frame_limit;
    } gen_config_t;

    // XNOR feedback so the all-zero reset state is a legal member of the sequence
    function automatic logic [15:0] lfsr16(input logic [15:0] s);
        return {s[14:0], ~(s[15] ^ s[13] ^ s[12] ^ s[10])};
    endfunction

    function automatic logic [15:0] ip_header_checksum(input logic [159:0] h);
        logic [19:0] sum;
        sum = '0;
        for (int i = 0; i < 10; i++) begin
            sum = sum + 20'(h[i*16 +: 16]);
        end
        sum = 20'(sum[15:0]) + 20'(sum[19:16]);
        sum = 20'(sum[15:0]) + 20'(sum[19:16]);
        return ~sum[15:0];
    endfunction

endpackage

// File: rtl/frame_generator_multi_size.sv
// Frame size sequencer: holds the latched size config plus the
// sweep / random state and presents the size of the current frame.
module frame_size_sequencer
    import tester_common::*;
(
    input  logic        clk,
    input  logic        rst,
    input  size_mode_t  mode,
    input  logic [13:0] size_min,
    input  logic [13:0] size_max,
    input  logic [13:0] size_step,
    input  logic        load,
    input  logic        advance,
    output logic [13:0] size
);

    size_mode_t  mode_q, mode_src;
    logic [13:0] min_q, max_q, step_q;
    logic [13:0] min_src, max_src;
    logic [15:0] lfsr_q, lfsr_n;
    logic [14:0] rnd_sum, sweep_sum;
    logic [13:0] rnd_size, sweep_size, size_n;

    always_comb begin
        lfsr_n   = lfsr16(lfsr_q);
        mode_src = load ? mode : mode_q;
        min_src  = load ? size_min : min_q;
        max_src  = load ? size_max : max_q;

        rnd_sum  = {1'b0, min_src} + {1'b0, lfsr_n[13:0]};
        rnd_size = (rnd_sum > {1'b0, max_src}) ? max_src : rnd_sum[13:0];

        sweep_sum  = {1'b0, size} + {1'b0, step_q};
        sweep_size = (sweep_sum > {1'b0, max_q}) ? min_q : sweep_sum[13:0];

        case (mode_src)
            SIZE_SWEEP:  size_n = load ? min_src : sweep_size;
            SIZE_RANDOM: size_n = rnd_size;
            default:     size_n = min_src;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= SIZE_FIXED;
            min_q  <= '0;
            max_q  <= '0;
            step_q <= '0;
            lfsr_q <= '0;
            size   <= '0;
        end else if (load) begin
            mode_q <= mode;
            min_q  <= size_min;
            max_q  <= size_max;
            step_q <= size_step;
            lfsr_q <= lfsr_n;
            size   <= size_n;
        end else if (advance) begin
            lfsr_q <= lfsr_n;
            size   <= size_n;
        end
    end

endmodule

// File: rtl/frame_generator_multi.sv
// IPv4-over-Ethernet test frame source on an AXI-Stream master with
// fixed/sweep/random sizing, inter-frame gap and frame-count limit.
module frame_generator_multi
    import tester_common::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 3,
    parameter int SEQ_WIDTH  = 32,
    parameter int CNT_WIDTH  = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  gen_config_t             cfg,
    output logic                    ready,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    frames_sent,
    output logic [CNT_WIDTH-1:0]    bytes_sent,
    output logic [DATA_WIDTH-1:0]   axis_m_data,
    output logic [DATA_WIDTH/8-1:0] axis_m_keep,
    output logic                    axis_m_last,
    output logic                    axis_m_user,
    output logic [ID_WIDTH-1:0]     axis_m_id,
    output logic                    axis_m_valid,
    input  logic                    axis_m_ready
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int HDR_BYTES  = SEQ_OFFSET + SEQ_WIDTH / 8;
    localparam logic [13:0] BEAT_SZ = 14'(BEAT_BYTES);

    gen_state_t state, state_n;

    logic [47:0] src_mac_q, dst_mac_q;
    logic [31:0] src_ip_q, dst_ip_q, limit_q;
    logic [15:0] gap_q, gap_cnt;
    logic        stop_q;
    logic [13:0] sent, size, remain;
    logic [15:0] frame_lfsr, frame_lfsr_n, ip_id, content;
    logic [SEQ_WIDTH-1:0] seq_q;

    logic start_acc, beat_acc, last_acc, limit_hit, stop_now;
    logic next_frame, first_beat, beat_last;

    logic [15:0]             ip_len, csum;
    logic [159:0]            ip_hdr;
    logic [HDR_BYTES*8-1:0]  hdr;
    logic [7:0]              fill;
    logic [BEAT_BYTES-1:0]   beat_keep;
    logic [DATA_WIDTH-1:0]   beat_data;

    frame_size_sequencer u_size (
        .clk       (clk),
        .rst       (rst),
        .mode      (cfg.size_mode),
        .size_min  (cfg.size_min),
        .size_max  (cfg.size_max),
        .size_step (cfg.size_step),
        .load      (start_acc),
        .advance   (last_acc),
        .size      (size)
    );

    // valid/ready/busy drop combinationally with rst so a frame is cut at once
    assign axis_m_valid = (state == ST_SENDING) && !rst;
    assign ready        = (state == ST_IDLE) && !rst;
    assign busy         = (state != ST_IDLE) && !rst;
    assign axis_m_data  = axis_m_valid ? beat_data : '0;
    assign axis_m_keep  = axis_m_valid ? beat_keep : '0;
    assign axis_m_last  = axis_m_valid && beat_last;
    assign axis_m_user  = 1'b0;
    assign axis_m_id    = '0;

    always_comb begin
        remain       = size - sent;
        beat_last    = (remain <= BEAT_SZ);
        first_beat   = (sent == '0);
        beat_acc     = axis_m_valid && axis_m_ready;
        last_acc     = beat_acc && beat_last;
        start_acc    = (state == ST_IDLE) && start && cfg.enable;
        limit_hit    = (limit_q != '0) &&
                       ((frames_sent + CNT_WIDTH'(1)) == CNT_WIDTH'(limit_q));
        stop_now     = stop_q || stop;
        frame_lfsr_n = lfsr16(frame_lfsr);

        state_n = state;
        case (state)
            ST_IDLE: begin
                if (start_acc) state_n = ST_SENDING;
            end
            ST_SENDING: begin
                if (last_acc) begin
                    if (stop_now || limit_hit) state_n = ST_IDLE;
                    else if (gap_q != '0)      state_n = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == 16'd1) state_n = stop_now ? ST_IDLE : ST_SENDING;
            end
            default: state_n = ST_IDLE;
        endcase

        next_frame = (state_n == ST_SENDING) &&
                     ((state != ST_SENDING) || last_acc);
    end

    always_comb begin
        ip_len = {2'b00, size} - 16'd14;
        csum   = ip_header_checksum({8'h45, TEST_FRAME_TOS, ip_len, ip_id,
                                     16'h0000, TEST_FRAME_TTL,
                                     TEST_FRAME_PROTO, 16'h0000,
                                     src_ip_q, dst_ip_q});
        ip_hdr = {8'h45, TEST_FRAME_TOS, ip_len, ip_id, 16'h0000,
                  TEST_FRAME_TTL, TEST_FRAME_PROTO, csum,
                  src_ip_q, dst_ip_q};
        hdr    = {dst_mac_q, src_mac_q, 16'h0800, ip_hdr, seq_q};

        fill      = '0;
        beat_data = '0;
        beat_keep = '0;
        // byte 0 sits in the low lane; header only overlays the first beat
        for (int i = 0; i < BEAT_BYTES; i++) begin
            fill = i[0] ? content[7:0] : content[15:8];
            if (first_beat && i < HDR_BYTES) begin
                fill = hdr[(HDR_BYTES-1-i)*8 +: 8];
            end
            beat_data[i*8 +: 8] = fill;
            beat_keep[i]        = (14'(i) < remain);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            done        <= 1'b0;
            stop_q      <= 1'b0;
            src_mac_q   <= '0;
            dst_mac_q   <= '0;
            src_ip_q    <= '0;
            dst_ip_q    <= '0;
            limit_q     <= '0;
            gap_q       <= '0;
            gap_cnt     <= '0;
            sent        <= '0;
            seq_q       <= '0;
            frames_sent <= '0;
            bytes_sent  <= '0;
            frame_lfsr  <= '0;
            ip_id       <= '0;
            content     <= '0;
        end else begin
            state  <= state_n;
            done   <= (state != ST_IDLE) && (state_n == ST_IDLE);
            stop_q <= (state != ST_IDLE) && stop_now;

            if (start_acc) begin
                src_mac_q   <= cfg.src_mac;
                dst_mac_q   <= cfg.dst_mac;
                src_ip_q    <= cfg.src_ip;
                dst_ip_q    <= cfg.dst_ip;
                limit_q     <= cfg.frame_limit;
                gap_q       <= cfg.gap_cycles;
                sent        <= '0;
                seq_q       <= '0;
                frames_sent <= '0;
                bytes_sent  <= '0;
            end

            if (beat_acc) begin
                content <= lfsr16(content);
                if (beat_last) begin
                    sent        <= '0;
                    seq_q       <= seq_q + SEQ_WIDTH'(1);
                    frames_sent <= frames_sent + CNT_WIDTH'(1);
                    bytes_sent  <= bytes_sent + CNT_WIDTH'(size);
                end else begin
                    sent <= sent + BEAT_SZ;
                end
            end

            if (last_acc && state_n == ST_GAP) gap_cnt <= gap_q;
            else if (state == ST_GAP)          gap_cnt <= gap_cnt - 16'd1;

            if (next_frame) begin
                frame_lfsr <= frame_lfsr_n;
                ip_id      <= frame_lfsr_n;
                content    <= frame_lfsr_n;
            end
        end
    end

endmodule
